// File: rtl/cgra_config_loader_if.sv
// Host-to-loader configuration bus: word stream in, active frames and status out.
// The loader owns the slave modport; the host (or bench) drives the master side.
interface cgra_config_loader_if #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int FRAME_WIDTH = 64,
  parameter int WORD_WIDTH  = 32
) ();
  logic                              start;
  logic                              abort;
  logic [WORD_WIDTH-1:0]             s_data;
  logic                              s_valid;
  logic                              s_last;
  logic                              s_ready;
  logic [ROWS*COLS*FRAME_WIDTH-1:0]  config_frames;
  logic                              config_valid;
  logic                              busy;
  logic                              done;
  logic                              error;

  modport master (
    output start, abort, s_data, s_valid, s_last,
    input  s_ready, config_frames, config_valid, busy, done, error
  );

  modport slave (
    input  start, abort, s_data, s_valid, s_last,
    output s_ready, config_frames, config_valid, busy, done, error
  );
endinterface

// File: rtl/cgra_config_loader.sv
// Assembles a word stream into shadow PE frames and commits them atomically; commit strobe
// one cycle after the last word, s_ready held high for the whole load and low otherwise.
module cgra_config_loader #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int FRAME_WIDTH = 64,
  parameter int WORD_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  cgra_config_loader_if.slave   bus
);
  localparam int WPF    = FRAME_WIDTH / WORD_WIDTH;
  localparam int NWORDS = ROWS * COLS * WPF;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                              r_state;
  logic [CNT_W-1:0]                    r_cnt;
  logic [NWORDS-1:0][WORD_WIDTH-1:0]   r_shadow;
  logic [ROWS*COLS*FRAME_WIDTH-1:0]    r_frames;
  logic                                r_s_ready;
  logic                                r_config_valid;
  logic                                r_busy;
  logic                                r_done;
  logic                                r_error;

  logic [NWORDS-1:0][WORD_WIDTH-1:0]   w_merged;
  logic                                w_xfer;
  logic                                w_at_last;

  // Word k lands at bit k*WORD_WIDTH, which is exactly frame k/WPF, slice k%WPF.
  always_comb begin
    w_merged        = r_shadow;
    w_merged[r_cnt] = bus.s_data;
  end

  assign w_xfer    = bus.s_valid & r_s_ready;
  assign w_at_last = (r_cnt == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_shadow       <= '0;
      r_frames       <= '0;
      r_s_ready      <= 1'b0;
      r_config_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_config_valid <= 1'b0;
          r_done         <= 1'b0;
          if (bus.start) begin
            r_state   <= ST_LOAD;
            r_cnt     <= '0;
            r_error   <= 1'b0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ST_LOAD: begin
          // Abort wins over a same-cycle word so nothing of the load survives.
          if (bus.abort) begin
            r_state   <= ST_IDLE;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
          end else if (w_xfer) begin
            r_shadow <= w_merged;
            r_cnt    <= r_cnt + 1'b1;
            if (bus.s_last && w_at_last) begin
              r_frames       <= w_merged;
              r_state        <= ST_COMMIT;
              r_s_ready      <= 1'b0;
              r_config_valid <= 1'b1;
              r_done         <= 1'b1;
            end else if (bus.s_last || w_at_last) begin
              r_state   <= ST_IDLE;
              r_s_ready <= 1'b0;
              r_busy    <= 1'b0;
              r_error   <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          r_state        <= ST_IDLE;
          r_config_valid <= 1'b0;
          r_done         <= 1'b0;
          r_busy         <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_s_ready <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready       = r_s_ready;
  assign bus.config_frames = r_frames;
  assign bus.config_valid  = r_config_valid;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.error         = r_error;
endmodule
